// File: rtl/truth_table_checker_if.sv
// Handshake bundle between the truth-table checker and its controller/unit-under-test side.
// The slave modport is the checker; the master modport drives start and returns the unit output.
interface truth_table_checker_if #(
    parameter int unsigned N_IN = 4
);
    logic              start;
    logic              y_in;
    logic [N_IN-1:0]   vec_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     err_count;
    logic              first_fail_valid;
    logic [N_IN-1:0]   first_fail_idx;

    modport master (
        output start,
        output y_in,
        input  vec_out,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_fail_valid,
        input  first_fail_idx
    );

    modport slave (
        input  start,
        input  y_in,
        output vec_out,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_fail_valid,
        output first_fail_idx
    );
endinterface

// File: rtl/truth_table_checker.sv
// Exhaustive sweep of all input vectors into a combinational unit, comparing each sampled
// output bit against a fixed expected truth table and latching an on-chip verdict.
module truth_table_checker #(
    parameter int unsigned              N_IN     = 4,
    parameter logic [(2**N_IN)-1:0]     EXPECTED = 16'hB2C4,
    parameter int unsigned              HOLD     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_checker_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0]      HOLD_LAST = 4'(HOLD - 1);
    localparam logic [N_IN-1:0] VEC_LAST  = '1;

    state_t            state, state_n;
    logic [N_IN-1:0]   vec_q, vec_n;
    logic [3:0]        hold_q, hold_n;
    logic [N_IN:0]     err_q, err_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              pass_q, pass_n;
    logic              ffv_q, ffv_n;
    logic [N_IN-1:0]   ffi_q, ffi_n;
    logic              mismatch;
    logic [N_IN:0]     err_upd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            vec_q  <= '0;
            hold_q <= '0;
            err_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            ffv_q  <= 1'b0;
            ffi_q  <= '0;
        end else begin
            state  <= state_n;
            vec_q  <= vec_n;
            hold_q <= hold_n;
            err_q  <= err_n;
            busy_q <= busy_n;
            done_q <= done_n;
            pass_q <= pass_n;
            ffv_q  <= ffv_n;
            ffi_q  <= ffi_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (bus.start) state_n = RUN;
            RUN:        if (hold_q == HOLD_LAST && vec_q == VEC_LAST) state_n = DONE;
            default:    state_n = IDLE;
        endcase
    end

    always_comb begin
        vec_n    = vec_q;
        hold_n   = hold_q;
        err_n    = err_q;
        busy_n   = busy_q;
        done_n   = done_q;
        pass_n   = pass_q;
        ffv_n    = ffv_q;
        ffi_n    = ffi_q;
        // An unknown y_in falls through to the else branch, so it is scored as a mismatch.
        if (bus.y_in == EXPECTED[vec_q]) mismatch = 1'b0;
        else                             mismatch = 1'b1;
        err_upd  = err_q + {{N_IN{1'b0}}, mismatch};
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    vec_n  = '0;
                    hold_n = '0;
                    err_n  = '0;
                    ffv_n  = 1'b0;
                    ffi_n  = '0;
                    busy_n = 1'b1;
                    done_n = 1'b0;
                    pass_n = 1'b0;
                end
            end
            RUN: begin
                if (hold_q != HOLD_LAST) begin
                    hold_n = hold_q + 4'd1;
                end else begin
                    err_n = err_upd;
                    if (mismatch && !ffv_q) begin
                        ffv_n = 1'b1;
                        ffi_n = vec_q;
                    end
                    if (vec_q != VEC_LAST) begin
                        vec_n  = vec_q + 1'b1;
                        hold_n = '0;
                    end else begin
                        busy_n = 1'b0;
                        done_n = 1'b1;
                        pass_n = (err_upd == '0);
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.vec_out          = vec_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_idx   = ffi_q;
endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: three instances (HOLD=2,3,1) fed by a fault-injectable golden unit.
module tb_truth_table_checker;
    localparam logic [15:0] EXP = 16'hB2C4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0]       start_v = '0;
    logic [15:0]      flip    = '0;
    logic [2:0]       busy_v, done_v, pass_v, ffv_v;
    logic [2:0][3:0]  vec_v, ffi_v;
    logic [2:0][4:0]  err_v;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        truth_table_checker_if #(.N_IN(4)) bus ();
        assign bus.start = start_v[g];
        assign bus.y_in  = EXP[bus.vec_out] ^ flip[bus.vec_out];
        assign busy_v[g] = bus.busy;
        assign done_v[g] = bus.done;
        assign pass_v[g] = bus.pass;
        assign ffv_v[g]  = bus.first_fail_valid;
        assign vec_v[g]  = bus.vec_out;
        assign ffi_v[g]  = bus.first_fail_idx;
        assign err_v[g]  = bus.err_count;
        truth_table_checker #(
            .N_IN(4),
            .EXPECTED(16'hB2C4),
            .HOLD(g == 0 ? 2 : (g == 1 ? 3 : 1))
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    function automatic int hold_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 3 : 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input int g);
        check("rst_vec",  32'(vec_v[g]),  0);
        check("rst_busy", 32'(busy_v[g]), 0);
        check("rst_done", 32'(done_v[g]), 0);
        check("rst_pass", 32'(pass_v[g]), 0);
        check("rst_err",  32'(err_v[g]),  0);
        check("rst_ffv",  32'(ffv_v[g]),  0);
        check("rst_ffi",  32'(ffi_v[g]),  0);
    endtask

    // Full sweep on instance g with the given fault mask; verdict derived from the mask alone.
    task automatic run_sweep(input int g, input logic [15:0] mask, input bit repulse);
        int hold = hold_of(g);
        int total = 16 * hold;
        int exp_err = 0;
        int exp_ffi = 0;
        bit found = 0;
        for (int k = 0; k < 16; k++) begin
            if (mask[k]) begin
                exp_err++;
                if (!found) begin exp_ffi = k; found = 1; end
            end
        end
        flip = mask;
        start_v[g] = 1'b1;
        tick();
        start_v[g] = 1'b0;
        check("start_busy", 32'(busy_v[g]), 1);
        check("start_done", 32'(done_v[g]), 0);
        check("start_vec",  32'(vec_v[g]),  0);
        check("start_err",  32'(err_v[g]),  0);
        check("start_ffv",  32'(ffv_v[g]),  0);
        check("start_pass", 32'(pass_v[g]), 0);
        for (int c = 1; c <= total; c++) begin
            if (repulse && (c == 5 || c == 20) && c < total) start_v[g] = 1'b1;
            tick();
            start_v[g] = 1'b0;
            check("run_vec",  32'(vec_v[g]),  (c < total) ? 32'(c / hold) : 32'd15);
            check("run_busy", 32'(busy_v[g]), (c < total) ? 1 : 0);
            check("run_done", 32'(done_v[g]), (c == total) ? 1 : 0);
        end
        check("end_err",  32'(err_v[g]),  32'(exp_err));
        check("end_ffv",  32'(ffv_v[g]),  (exp_err > 0) ? 1 : 0);
        check("end_ffi",  32'(ffi_v[g]),  32'(exp_ffi));
        check("end_pass", 32'(pass_v[g]), (exp_err == 0) ? 1 : 0);
        tick();
        check("hold_done", 32'(done_v[g]), 1);
        check("hold_vec",  32'(vec_v[g]),  15);
        check("hold_err",  32'(err_v[g]),  32'(exp_err));
    endtask

    initial begin
        tick();
        tick();
        for (int g = 0; g < 3; g++) check_zero(g);
        rst = 1'b0;
        tick();

        run_sweep(0, 16'h0000, 1'b1);
        run_sweep(0, 16'hFFFF, 1'b0);
        run_sweep(0, 16'h0200, 1'b0);
        run_sweep(0, 16'h1200, 1'b1);
        run_sweep(1, 16'h0000, 1'b0);
        run_sweep(2, 16'hFFFF, 1'b0);
        run_sweep(2, 16'h0000, 1'b0);

        // Reset mid-sweep while vector 5 is presented.
        flip = '0;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int c = 1; c <= 10; c++) tick();
        check("mid_vec", 32'(vec_v[0]), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero(0);
        tick();
        check("idle_busy", 32'(busy_v[0]), 0);
        run_sweep(0, 16'h0000, 1'b0);

        // rst and start together: rst wins.
        rst = 1'b1;
        start_v[0] = 1'b1;
        tick();
        rst = 1'b0;
        start_v[0] = 1'b0;
        check_zero(0);
        tick();
        check("rs_busy", 32'(busy_v[0]), 0);

        for (int i = 0; i < 6; i++) begin
            logic [15:0] m;
            int g;
            g = int'($urandom_range(0, 2));
            case ($urandom_range(0, 2))
                0:       m = 16'($urandom);
                1:       m = 16'($urandom & $urandom & $urandom);
                default: m = 16'h1 << $urandom_range(0, 15);
            endcase
            run_sweep(g, m, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
